// File: rtl/uart_packet_engine_if.sv
// Byte-level handshake between the packet engine (master) and the UART core (slave).
interface uart_packet_engine_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_clear;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  logic       tx_busy;

  modport master (
    input  rx_data, rx_ready, tx_busy,
    output rx_clear, tx_data, tx_wr_en
  );

  modport slave (
    output rx_data, rx_ready, tx_busy,
    input  rx_clear, tx_data, tx_wr_en
  );
endinterface

// File: rtl/uart_packet_engine.sv
// Byte-stream framer: assembles received header frames with idle-timeout resync and
// serialises nonces MSB-first to the UART, with a one-entry pending buffer.
module uart_packet_engine #(
  parameter int HEADER_BYTES   = 80,
  parameter int NONCE_BYTES    = 4,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  uart_packet_engine_if.master      uart,
  input  logic [NONCE_BYTES*8-1:0]  nonce_in,
  input  logic                      nonce_valid,
  output logic [HEADER_BYTES*8-1:0] header_data,
  output logic                      header_valid,
  output logic                      rx_timeout,
  output logic                      nonce_drop,
  output logic                      tx_idle,
  output logic [31:0]               byte_count
);
  localparam int HW    = HEADER_BYTES * 8;
  localparam int NW    = NONCE_BYTES * 8;
  localparam int IDX_W = $clog2(HEADER_BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int REM_W = $clog2(NONCE_BYTES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_ACK, ST_DONE} tx_state_t;

  logic [HW-1:0]    r_asm;
  logic [HW-1:0]    r_header;
  logic [IDX_W-1:0] r_idx;
  logic [TO_W-1:0]  r_to_cnt;
  logic [31:0]      r_byte_count;
  logic             r_rx_clear;
  logic             r_hdr_valid;
  logic             r_rx_timeout;

  logic             w_accept;
  logic             w_last;
  logic             w_expire;
  logic [HW-1:0]    w_asm_nx;

  tx_state_t        r_state, w_state_nx;
  logic [NW-1:0]    r_shift, w_shift_nx;
  logic [REM_W-1:0] r_rem, w_rem_nx;
  logic [1:0]       r_ack_cnt, w_ack_nx;
  logic             r_tx_wr, w_tx_wr_nx;
  logic [7:0]       r_tx_data, w_tx_data_nx;
  logic             r_pend_v, w_pend_v_nx;
  logic [NW-1:0]    r_pend, w_pend_nx;
  logic             r_drop, w_drop_nx;
  logic             w_take_direct;

  // rx_clear masks the UART's one-cycle lag in dropping rx_ready.
  assign w_accept = uart.rx_ready && !r_rx_clear;
  assign w_last   = (r_idx == IDX_W'(HEADER_BYTES - 1));
  assign w_expire = (r_idx != '0) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Next assembly value: shift in the received byte at the LSB end.
  always_comb begin
    w_asm_nx      = r_asm << 8;
    w_asm_nx[7:0] = uart.rx_data;
  end

  // RX framing, timeout resync and byte counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_asm        <= '0;
      r_header     <= '0;
      r_idx        <= '0;
      r_to_cnt     <= '0;
      r_byte_count <= 32'd0;
      r_rx_clear   <= 1'b0;
      r_hdr_valid  <= 1'b0;
      r_rx_timeout <= 1'b0;
    end else begin
      r_rx_clear   <= w_accept;
      r_hdr_valid  <= 1'b0;
      r_rx_timeout <= 1'b0;
      if (w_accept) begin
        r_asm        <= w_asm_nx;
        r_byte_count <= r_byte_count + 32'd1;
        r_to_cnt     <= '0;
        if (w_last) begin
          r_idx       <= '0;
          r_header    <= w_asm_nx;
          r_hdr_valid <= 1'b1;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else if (w_expire) begin
        r_idx        <= '0;
        r_to_cnt     <= '0;
        r_rx_timeout <= 1'b1;
      end else if (r_idx != '0) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // TX state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // TX next-state, datapath and pending-buffer decisions.
  always_comb begin
    w_state_nx    = r_state;
    w_shift_nx    = r_shift;
    w_rem_nx      = r_rem;
    w_ack_nx      = r_ack_cnt;
    w_tx_wr_nx    = 1'b0;
    w_tx_data_nx  = r_tx_data;
    w_pend_v_nx   = r_pend_v;
    w_pend_nx     = r_pend;
    w_drop_nx     = 1'b0;
    w_take_direct = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_v) begin
          w_shift_nx  = r_pend;
          w_rem_nx    = REM_W'(NONCE_BYTES);
          w_pend_v_nx = 1'b0;
          w_state_nx  = ST_SEND;
        end else if (nonce_valid) begin
          w_shift_nx    = nonce_in;
          w_rem_nx      = REM_W'(NONCE_BYTES);
          w_take_direct = 1'b1;
          w_state_nx    = ST_SEND;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!uart.tx_busy) begin
          w_tx_wr_nx   = 1'b1;
          w_tx_data_nx = r_shift[NW-1 -: 8];
          w_ack_nx     = 2'd0;
          w_state_nx   = ST_ACK;
        end else begin
          w_state_nx = ST_SEND;
        end
      end
      ST_ACK: begin
        // Give up waiting for busy after four cycles so a missed ack cannot hang TX.
        if (uart.tx_busy || (r_ack_cnt == 2'd3)) begin
          w_state_nx = ST_DONE;
        end else begin
          w_ack_nx = r_ack_cnt + 2'd1;
        end
      end
      ST_DONE: begin
        if (!uart.tx_busy) begin
          w_shift_nx = r_shift << 8;
          w_rem_nx   = r_rem - REM_W'(1);
          w_state_nx = (r_rem == REM_W'(1)) ? ST_IDLE : ST_SEND;
        end else begin
          w_state_nx = ST_DONE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    if (nonce_valid && !w_take_direct) begin
      if (!r_pend_v) begin
        w_pend_v_nx = 1'b1;
        w_pend_nx   = nonce_in;
      end else begin
        w_drop_nx = 1'b1;
      end
    end else begin
      w_drop_nx = 1'b0;
    end
  end

  // TX datapath and pending-buffer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_rem     <= '0;
      r_ack_cnt <= 2'd0;
      r_tx_wr   <= 1'b0;
      r_tx_data <= 8'd0;
      r_pend_v  <= 1'b0;
      r_pend    <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_shift   <= w_shift_nx;
      r_rem     <= w_rem_nx;
      r_ack_cnt <= w_ack_nx;
      r_tx_wr   <= w_tx_wr_nx;
      r_tx_data <= w_tx_data_nx;
      r_pend_v  <= w_pend_v_nx;
      r_pend    <= w_pend_nx;
      r_drop    <= w_drop_nx;
    end
  end

  assign uart.rx_clear = r_rx_clear;
  assign uart.tx_data  = r_tx_data;
  assign uart.tx_wr_en = r_tx_wr;
  assign header_data   = r_header;
  assign header_valid  = r_hdr_valid;
  assign rx_timeout    = r_rx_timeout;
  assign nonce_drop    = r_drop;
  assign byte_count    = r_byte_count;
  assign tx_idle       = (r_state == ST_IDLE) && !r_pend_v && !nonce_valid;

endmodule

// File: tb/tb_uart_packet_engine.sv
// Directed, table-driven bench for uart_packet_engine with a simple UART busy model.
module tb_uart_packet_engine;
  logic        clk;
  logic        reset;
  logic [31:0] nonce_in;
  logic        nonce_valid;
  logic [31:0] header_data;
  logic        header_valid;
  logic        rx_timeout;
  logic        nonce_drop;
  logic        tx_idle;
  logic [31:0] byte_count;

  uart_packet_engine_if u_if();

  uart_packet_engine #(
    .HEADER_BYTES  (4),
    .NONCE_BYTES   (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .uart        (u_if),
    .nonce_in    (nonce_in),
    .nonce_valid (nonce_valid),
    .header_data (header_data),
    .header_valid(header_valid),
    .rx_timeout  (rx_timeout),
    .nonce_drop  (nonce_drop),
    .tx_idle     (tx_idle),
    .byte_count  (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Event counters and UART transmitter model (busy 10 cycles per strobe).
  int       hv_cnt = 0, to_cnt = 0, drop_cnt = 0, clr_cnt = 0, wr_cnt = 0;
  int       busy_left = 0;
  logic [7:0] wr_log [0:63];

  always @(negedge clk) begin
    if (header_valid === 1'b1) hv_cnt++;
    if (rx_timeout === 1'b1) to_cnt++;
    if (nonce_drop === 1'b1) drop_cnt++;
    if (u_if.rx_clear === 1'b1) clr_cnt++;
    if (u_if.tx_wr_en === 1'b1) begin
      wr_log[wr_cnt % 64] = u_if.tx_data;
      wr_cnt++;
      busy_left = 10;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    u_if.tx_busy = (busy_left > 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one byte with the UART's lag: rx_ready stays up across two edges.
  task automatic send_byte(input logic [7:0] b, output logic hv, output logic clr_ok);
    logic c1;
    u_if.rx_data  = b;
    u_if.rx_ready = 1'b1;
    @(negedge clk);
    hv = header_valid;
    c1 = u_if.rx_clear;
    @(negedge clk);
    clr_ok = (c1 === 1'b1) && (u_if.rx_clear === 1'b0);
    u_if.rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] bytes, output logic hv_ok, output logic clr_ok);
    logic hv, c;
    hv_ok  = 1'b1;
    clr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[31-8*i -: 8], hv, c);
      hv_ok  = hv_ok && (hv === (i == 3));
      clr_ok = clr_ok && c;
    end
  endtask

  task automatic pulse_nonce(input logic [31:0] n);
    nonce_in    = n;
    nonce_valid = 1'b1;
    @(negedge clk);
    nonce_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] bytes;
    logic [31:0] exp_hdr;
    logic [31:0] exp_cnt;
  } hdr_vec_t;

  hdr_vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hv_ok, clr_ok, hv, c, seen_early, done;
    int          s_hv, s_clr, s_to, s_wr, s_drop, w;
    logic [31:0] exp_nonce;

    vecs[0] = '{32'h0102_0304, 32'h0102_0304, 32'd4};
    vecs[1] = '{32'hA55A_FF00, 32'hA55A_FF00, 32'd8};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'd12};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd16};

    reset         = 1'b0;
    u_if.rx_data  = 8'h00;
    u_if.rx_ready = 1'b0;
    nonce_in      = 32'd0;
    nonce_valid   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_header", header_data, 32'd0);
    check("rst_count", byte_count, 32'd0);
    check("rst_tx_idle", tx_idle, 1'b1);
    check("rst_strobes", {u_if.rx_clear, u_if.tx_wr_en, header_valid, rx_timeout, nonce_drop}, 5'b0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      s_hv  = hv_cnt;
      s_clr = clr_cnt;
      send_frame(vecs[v].bytes, hv_ok, clr_ok);
      check($sformatf("hdr_data_%0d", v), header_data, vecs[v].exp_hdr);
      check($sformatf("hdr_pulse_at_last_%0d", v), hv_ok, 1'b1);
      check($sformatf("hdr_pulse_cnt_%0d", v), hv_cnt - s_hv, 1);
      check($sformatf("clr_single_%0d", v), clr_ok, 1'b1);
      check($sformatf("clr_cnt_%0d", v), clr_cnt - s_clr, 4);
      check($sformatf("byte_count_%0d", v), byte_count, vecs[v].exp_cnt);
    end

    // Partial frame then idle: pulse exactly 16 clocks after the last accept.
    s_to = to_cnt;
    send_byte(8'h77, hv, c);
    send_byte(8'h88, hv, c);
    seen_early = 1'b0;
    for (int k = 2; k < 16; k++) begin
      @(negedge clk);
      if (rx_timeout === 1'b1) seen_early = 1'b1;
    end
    check("timeout_not_early", seen_early, 1'b0);
    @(negedge clk);
    check("timeout_pulse", rx_timeout, 1'b1);
    @(negedge clk);
    check("timeout_one_cycle", rx_timeout, 1'b0);
    check("timeout_hdr_kept", header_data, 32'hFFFF_FFFF);
    send_frame(32'hA1A2_A3A4, hv_ok, clr_ok);
    check("resync_header", header_data, 32'hA1A2_A3A4);
    check("resync_pulse", hv_ok, 1'b1);
    check("timeout_count", to_cnt - s_to, 1);
    check("resync_byte_count", byte_count, 32'd22);

    // Single nonce: strobe two cycles after the request, then MSB-first bytes.
    s_wr = wr_cnt;
    check("tx_idle_before", tx_idle, 1'b1);
    pulse_nonce(32'hDEAD_BEEF);
    check("tx_no_early_strobe", u_if.tx_wr_en, 1'b0);
    check("tx_busy_flag", tx_idle, 1'b0);
    @(negedge clk);
    check("tx_first_strobe", {u_if.tx_wr_en, u_if.tx_data}, {1'b1, 8'hDE});
    w = 0;
    while (tx_idle !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    done = (w < 300);
    check("tx_done_in_budget", done, 1'b1);
    check("tx_strobe_count", wr_cnt - s_wr, 4);
    exp_nonce = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++)
      check($sformatf("tx_byte_%0d", i), wr_log[(s_wr + i) % 64], exp_nonce[31-8*i -: 8]);
    check("tx_data_hold", u_if.tx_data, 8'hEF);

    // Pending and drop: second request buffered, third discarded.
    repeat (12) @(negedge clk);
    s_wr   = wr_cnt;
    s_drop = drop_cnt;
    pulse_nonce(32'h1111_1111);
    pulse_nonce(32'h2222_2222);
    pulse_nonce(32'h3333_3333);
    w = 0;
    while (tx_idle !== 1'b1 && w < 600) begin
      @(negedge clk);
      w++;
    end
    done = (w < 600);
    check("pend_done_in_budget", done, 1'b1);
    check("pend_strobe_count", wr_cnt - s_wr, 8);
    check("pend_drop_count", drop_cnt - s_drop, 1);
    for (int i = 0; i < 8; i++)
      check($sformatf("pend_byte_%0d", i), wr_log[(s_wr + i) % 64], (i < 4) ? 8'h11 : 8'h22);

    // Reset in the middle of an RX frame and a TX nonce.
    repeat (12) @(negedge clk);
    send_byte(8'h5A, hv, c);
    send_byte(8'h5B, hv, c);
    s_wr = wr_cnt;
    pulse_nonce(32'hCAFE_BABE);
    w = 0;
    while ((wr_cnt - s_wr) < 2 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("rst_mid_reached", w < 300, 1'b1);
    reset = 1'b0;
    #1;
    check("mrst_header", header_data, 32'd0);
    check("mrst_count", byte_count, 32'd0);
    check("mrst_tx_idle", tx_idle, 1'b1);
    check("mrst_strobes", {u_if.rx_clear, u_if.tx_wr_en, u_if.tx_data, header_valid, rx_timeout, nonce_drop}, 13'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    s_hv = hv_cnt;
    s_wr = wr_cnt;
    send_frame(32'h5566_7788, hv_ok, clr_ok);
    check("post_rst_header", header_data, 32'h5566_7788);
    check("post_rst_pulse", hv_cnt - s_hv, 1);
    check("post_rst_count", byte_count, 32'd4);
    check("post_rst_no_tx", wr_cnt - s_wr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
